// File: rtl/sequence_tx_scheduler_pkg.sv
// Shared constants, FSM encoding and the byte-count clamp used by the
// keyboard/mouse sequence scheduler.
package sequence_tx_scheduler_pkg;

  localparam int unsigned SEQ_MAX_BYTES = 4;
  localparam int unsigned SEQ_W         = 32;
  localparam int unsigned CNT_W         = 3;

  localparam logic PORT_KBD   = 1'b0;
  localparam logic PORT_MOUSE = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Producers may report up to 7; anything past the packed word width is capped.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] res;
    if (cnt > CNT_W'(SEQ_MAX_BYTES)) begin
      res = CNT_W'(SEQ_MAX_BYTES);
    end else begin
      res = cnt;
    end
    return res;
  endfunction

endpackage

// File: rtl/sequence_tx_scheduler_if.sv
// Producer strobes, UART byte handshake and status pulses of the scheduler.
// The scheduler is the slave side; the environment driving it is the master.
interface sequence_tx_scheduler_if;
  import sequence_tx_scheduler_pkg::*;

  logic [SEQ_W-1:0] kbd_sequence;
  logic [CNT_W-1:0] kbd_count;
  logic [SEQ_W-1:0] mouse_sequence;
  logic [CNT_W-1:0] mouse_count;
  logic             tx_ready;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             busy;
  logic             kbd_overflow;
  logic             mouse_coalesced;

  modport slave (
    input  kbd_sequence, kbd_count, mouse_sequence, mouse_count, tx_ready,
    output tx_data, tx_valid, busy, kbd_overflow, mouse_coalesced
  );

  modport master (
    output kbd_sequence, kbd_count, mouse_sequence, mouse_count, tx_ready,
    input  tx_data, tx_valid, busy, kbd_overflow, mouse_coalesced
  );

endinterface

// File: rtl/sequence_tx_scheduler_slot.sv
// One-deep pending buffer for a producer. COALESCE=0 drops a strobe that hits
// a full slot; COALESCE=1 overwrites it. Either case raises pulse_o next cycle.
module seq_pending_slot
  import sequence_tx_scheduler_pkg::*;
#(
  parameter bit COALESCE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEQ_W-1:0] strb_data_i,
  input  logic [CNT_W-1:0] strb_count_i,
  input  logic             grant_i,
  output logic             full_o,
  output logic [SEQ_W-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             pulse_o
);

  logic             full_q, full_d;
  logic [SEQ_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pulse_q, pulse_d;
  logic             strobe_s;

  assign strobe_s = (strb_count_i != 3'd0);

  // A grant frees the slot on this edge, so a same-edge strobe refills it silently.
  always_comb begin
    full_d  = full_q;
    data_d  = data_q;
    count_d = count_q;
    pulse_d = 1'b0;
    if (grant_i) begin
      full_d = strobe_s;
      if (strobe_s) begin
        data_d  = strb_data_i;
        count_d = clamp_count(strb_count_i);
      end else begin
        data_d  = data_q;
        count_d = count_q;
      end
    end else if (strobe_s) begin
      if (!full_q) begin
        full_d  = 1'b1;
        data_d  = strb_data_i;
        count_d = clamp_count(strb_count_i);
      end else if (COALESCE == 1'b1) begin
        data_d  = strb_data_i;
        count_d = clamp_count(strb_count_i);
        pulse_d = 1'b1;
      end else begin
        pulse_d = 1'b1;
      end
    end else begin
      full_d = full_q;
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q  <= 1'b0;
      data_q  <= 32'h0000_0000;
      count_q <= 3'd0;
      pulse_q <= 1'b0;
    end else begin
      full_q  <= full_d;
      data_q  <= data_d;
      count_q <= count_d;
      pulse_q <= pulse_d;
    end
  end

  assign full_o  = full_q;
  assign data_o  = data_q;
  assign count_o = count_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/sequence_tx_scheduler.sv
// Round-robin arbiter between the keyboard and mouse pending slots, plus the
// LSB-first byte serialiser feeding the UART over valid/ready.
module sequence_tx_scheduler
  import sequence_tx_scheduler_pkg::*;
(
  input logic                    clk,
  input logic                    reset,
  sequence_tx_scheduler_if.slave bus
);

  logic             kbd_full_s, mouse_full_s;
  logic [SEQ_W-1:0] kbd_data_s, mouse_data_s;
  logic [CNT_W-1:0] kbd_cnt_s, mouse_cnt_s;
  logic             kbd_pulse_s, mouse_pulse_s;
  logic             grant_kbd_s, grant_mouse_s;

  state_e           state_q, state_d;
  logic [SEQ_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             last_grant_q, last_grant_d;
  logic             busy_q, busy_d;

  seq_pending_slot #(.COALESCE(1'b0)) u_kbd_slot (
    .clk          (clk),
    .reset        (reset),
    .strb_data_i  (bus.kbd_sequence),
    .strb_count_i (bus.kbd_count),
    .grant_i      (grant_kbd_s),
    .full_o       (kbd_full_s),
    .data_o       (kbd_data_s),
    .count_o      (kbd_cnt_s),
    .pulse_o      (kbd_pulse_s)
  );

  seq_pending_slot #(.COALESCE(1'b1)) u_mouse_slot (
    .clk          (clk),
    .reset        (reset),
    .strb_data_i  (bus.mouse_sequence),
    .strb_count_i (bus.mouse_count),
    .grant_i      (grant_mouse_s),
    .full_o       (mouse_full_s),
    .data_o       (mouse_data_s),
    .count_o      (mouse_cnt_s),
    .pulse_o      (mouse_pulse_s)
  );

  // Arbitration, serialiser next state and busy look-ahead.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    remaining_d   = remaining_q;
    last_grant_d  = last_grant_q;
    grant_kbd_s   = 1'b0;
    grant_mouse_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (kbd_full_s && mouse_full_s) begin
          if (last_grant_q == PORT_KBD) begin
            grant_mouse_s = 1'b1;
          end else begin
            grant_kbd_s = 1'b1;
          end
        end else if (kbd_full_s) begin
          grant_kbd_s = 1'b1;
        end else if (mouse_full_s) begin
          grant_mouse_s = 1'b1;
        end else begin
          grant_kbd_s   = 1'b0;
          grant_mouse_s = 1'b0;
        end
        if (grant_kbd_s) begin
          shift_d      = kbd_data_s;
          remaining_d  = kbd_cnt_s;
          last_grant_d = PORT_KBD;
          state_d      = ST_SEND;
        end else if (grant_mouse_s) begin
          shift_d      = mouse_data_s;
          remaining_d  = mouse_cnt_s;
          last_grant_d = PORT_MOUSE;
          state_d      = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (bus.tx_ready) begin
          shift_d     = {8'h00, shift_q[SEQ_W-1:8]};
          remaining_d = remaining_q - 3'd1;
          if (remaining_q <= 3'd1) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A full slot that is not granted stays full; a granted one implies SEND next.
    busy_d = (state_d == ST_SEND) || kbd_full_s || mouse_full_s ||
             (bus.kbd_count != 3'd0) || (bus.mouse_count != 3'd0);
  end

  // Serialiser and arbiter state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      shift_q      <= 32'h0000_0000;
      remaining_q  <= 3'd0;
      last_grant_q <= PORT_KBD;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      remaining_q  <= remaining_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.tx_valid        = (state_q == ST_SEND);
  assign bus.tx_data         = shift_q[7:0];
  assign bus.busy            = busy_q;
  assign bus.kbd_overflow    = kbd_pulse_s;
  assign bus.mouse_coalesced = mouse_pulse_s;

endmodule

// File: tb/tb_sequence_tx_scheduler.sv
// Randomised and directed bench for sequence_tx_scheduler: a queue-based
// reference model predicts every transmitted byte and per-cycle status.
module tb_sequence_tx_scheduler;

  typedef byte unsigned bq_t[$];

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  sequence_tx_scheduler_if bus ();

  sequence_tx_scheduler dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model state: whole sequences as byte queues.
  bq_t m_kbd = {};
  bq_t m_mouse = {};
  bq_t m_cur = {};
  bq_t exp_q = {};
  bq_t log_q = {};
  bit  m_kfull = 1'b0, m_mfull = 1'b0, m_send = 1'b0;
  bit  m_last_mouse = 1'b0;
  bit  m_kovf = 1'b0, m_mcoal = 1'b0;
  int  kovf_seen = 0, mcoal_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bq_t unpack(input logic [31:0] d, input logic [2:0] c);
    bq_t q;
    int  n;
    q = {};
    n = (c > 3'd4) ? 4 : int'(c);
    for (int i = 0; i < n; i++) q.push_back(d[8*i +: 8]);
    return q;
  endfunction

  // Model: one step per clock edge, cleared by reset.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_kbd = {}; m_mouse = {}; m_cur = {}; exp_q = {};
        m_kfull = 1'b0; m_mfull = 1'b0; m_send = 1'b0; m_last_mouse = 1'b0;
        m_kovf = 1'b0; m_mcoal = 1'b0;
      end else begin
        bit gk, gm;
        gk = 1'b0; gm = 1'b0;
        if (m_send) begin
          if (bus.tx_ready) begin
            void'(m_cur.pop_front());
            if (m_cur.size() == 0) m_send = 1'b0;
          end
        end else if (m_kfull && m_mfull) begin
          if (m_last_mouse) gk = 1'b1; else gm = 1'b1;
        end else if (m_kfull) begin
          gk = 1'b1;
        end else if (m_mfull) begin
          gm = 1'b1;
        end
        if (gk) begin
          m_cur = m_kbd; exp_q = {exp_q, m_kbd};
          m_send = 1'b1; m_last_mouse = 1'b0; m_kfull = 1'b0;
        end
        if (gm) begin
          m_cur = m_mouse; exp_q = {exp_q, m_mouse};
          m_send = 1'b1; m_last_mouse = 1'b1; m_mfull = 1'b0;
        end
        m_kovf = 1'b0; m_mcoal = 1'b0;
        if (bus.kbd_count != 3'd0) begin
          if (m_kfull) m_kovf = 1'b1;
          else begin m_kbd = unpack(bus.kbd_sequence, bus.kbd_count); m_kfull = 1'b1; end
        end
        if (bus.mouse_count != 3'd0) begin
          if (m_mfull) m_mcoal = 1'b1;
          m_mouse = unpack(bus.mouse_sequence, bus.mouse_count); m_mfull = 1'b1;
        end
      end
    end
  end

  // Monitor: compares status every cycle and pops the scoreboard on each handshake.
  initial begin
    bit         prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      chk("tx_valid", 32'(bus.tx_valid), 32'(m_send));
      chk("busy", 32'(bus.busy), 32'(m_send || m_kfull || m_mfull));
      chk("kbd_overflow", 32'(bus.kbd_overflow), 32'(m_kovf));
      chk("mouse_coalesced", 32'(bus.mouse_coalesced), 32'(m_mcoal));
      if (bus.kbd_overflow) kovf_seen++;
      if (bus.mouse_coalesced) mcoal_seen++;
      if (prev_stall && rst_n) begin
        chk("hold_valid", 32'(bus.tx_valid), 32'd1);
        chk("hold_data", 32'(bus.tx_data), 32'(prev_data));
      end
      if (bus.tx_valid && bus.tx_ready && rst_n) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          chk("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
        end
        log_q.push_back(bus.tx_data);
      end
      prev_stall = rst_n && bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
    end
  end

  task automatic drive(input logic [31:0] kd, input logic [2:0] kc,
                       input logic [31:0] md, input logic [2:0] mc, input logic rdy);
    @(posedge clk); #1;
    bus.kbd_sequence = kd; bus.kbd_count = kc;
    bus.mouse_sequence = md; bus.mouse_count = mc;
    bus.tx_ready = rdy;
  endtask

  task automatic drain();
    int n;
    n = 0;
    drive(32'h0, 3'd0, 32'h0, 3'd0, 1'b1);
    while ((bus.busy || bus.tx_valid || exp_q.size() != 0) && n < 200) begin
      drive(32'h0, 3'd0, 32'h0, 3'd0, 1'b1);
      n++;
    end
    chk("drain_timeout", 32'(n >= 200), 32'd0);
    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.kbd_sequence = 32'h0; bus.kbd_count = 3'd0;
    bus.mouse_sequence = 32'h0; bus.mouse_count = 3'd0;
    bus.tx_ready = 1'b1;
    @(negedge clk);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_pulses", 32'({bus.kbd_overflow, bus.mouse_coalesced}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    log_q = {}; kovf_seen = 0; mcoal_seen = 0;
  endtask

  task automatic chk_log(input string name, input bq_t e);
    chk({name, "_len"}, 32'(log_q.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < log_q.size(); i++)
      chk({name, "_byte"}, 32'(log_q[i]), 32'(e[i]));
  endtask

  initial begin
    bq_t e;
    int  n;
    rst_n = 1'b0;
    bus.kbd_sequence = 32'h0; bus.kbd_count = 3'd0;
    bus.mouse_sequence = 32'h0; bus.mouse_count = 3'd0;
    bus.tx_ready = 1'b1;

    do_reset();
    drive(32'h0, 3'd0, 32'hA5C1801E, 3'd4, 1'b1);
    drain();
    e = '{8'h1E, 8'h80, 8'hC1, 8'hA5};
    chk_log("single_mouse", e);

    do_reset();
    drive(32'h0, 3'd0, 32'hA5C1801E, 3'd4, 1'b1);
    for (int i = 0; i < 16; i++) drive(32'h0, 3'd0, 32'h0, 3'd0, 1'(i % 2));
    drain();
    chk_log("backpressure", e);

    do_reset();
    drive(32'h00414243, 3'd3, 32'hA5C1801E, 3'd4, 1'b1);
    drain();
    e = '{8'h1E, 8'h80, 8'hC1, 8'hA5, 8'h43, 8'h42, 8'h41};
    chk_log("simultaneous", e);

    do_reset();
    drive(32'h00414243, 3'd3, 32'h0, 3'd0, 1'b0);
    drive(32'h0, 3'd0, 32'h0, 3'd0, 1'b0);
    drive(32'h0, 3'd0, 32'h0001001E, 3'd4, 1'b0);
    drive(32'h0, 3'd0, 32'h0, 3'd0, 1'b0);
    drive(32'h0, 3'd0, 32'h0002001E, 3'd4, 1'b0);
    drain();
    e = '{8'h43, 8'h42, 8'h41, 8'h1E, 8'h00, 8'h02, 8'h00};
    chk_log("coalesce", e);
    chk("coalesce_pulses", 32'(mcoal_seen), 32'd1);

    do_reset();
    drive(32'h00000A0B, 3'd2, 32'h0, 3'd0, 1'b0);
    drive(32'h0, 3'd0, 32'h0, 3'd0, 1'b0);
    drive(32'h0000000C, 3'd1, 32'h0, 3'd0, 1'b0);
    drive(32'h0, 3'd0, 32'h0, 3'd0, 1'b0);
    drive(32'h0000000D, 3'd1, 32'h0, 3'd0, 1'b0);
    drain();
    e = '{8'h0B, 8'h0A, 8'h0C};
    chk_log("overflow", e);
    chk("overflow_pulses", 32'(kovf_seen), 32'd1);

    do_reset();
    drive(32'h00003132, 3'd2, 32'h0, 3'd0, 1'b1);
    drive(32'h00000033, 3'd1, 32'h0, 3'd0, 1'b1);
    drain();
    e = '{8'h32, 8'h31, 8'h33};
    chk_log("same_edge", e);
    chk("same_edge_pulses", 32'(kovf_seen), 32'd0);

    do_reset();
    drive(32'h00414243, 3'd3, 32'hA5C1801E, 3'd4, 1'b1);
    drive(32'h0, 3'd0, 32'h0, 3'd0, 1'b1);
    n = 0;
    while (log_q.size() < 2 && n < 50) begin @(negedge clk); n++; end
    chk("midrst_reach", 32'(log_q.size()), 32'd2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.tx_valid), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) drive(32'h0, 3'd0, 32'h0, 3'd0, 1'b1);
    chk("midrst_nothing", 32'(log_q.size()), 32'd2);
    chk("midrst_idle_busy", 32'(bus.busy), 32'd0);

    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [2:0] kc, mc;
      kc = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      mc = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      drive($urandom, kc, $urandom, mc, 1'($urandom_range(0, 3) != 0));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
